wb_write_queue: RTL and testbench

Write-back queue for the 16-bit RISC core. It accepts results from the ALU and the load/store unit and buffers them in order in a small FIFO. It drains one entry per cycle into the general-purpose register file's single write port. It also tells the decode stage whether a source register still has a write pending.

---
 rtl/wb_write_queue_if.sv | 35 +++
 rtl/wb_write_queue.sv | 163 ++++++++++++++++
 tb/tb_wb_write_queue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Bus bundle for the write-back queue: ALU and load result handshakes, the
// hold request and the register-file write port.
interface wb_write_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic              wb_hold;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        input  wb_hold,
        output alu_ready, mem_ready,
        output reg_write_en, reg_write_dest, reg_write_data
    );

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        output wb_hold,
        input  alu_ready, mem_ready,
        input  reg_write_en, reg_write_dest, reg_write_data
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back FIFO feeding the register file write port, with a
// pending-write scoreboard. WB_QUEUE_BYPASS_EN adds youngest-match data forwarding.

// One queue slot: occupancy from its age relative to the read pointer,
// and the dest compare against both decode source addresses.
module wb_wq_slot #(
    parameter int IDX    = 0,
    parameter int PTR_W  = 2,
    parameter int CNT_W  = 3,
    parameter int ADDR_W = 4
) (
    input  logic [PTR_W-1:0]  rd_ptr,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] dest,
    input  logic [ADDR_W-1:0] chk_addr_1,
    input  logic [ADDR_W-1:0] chk_addr_2,
    output logic              hit_1,
    output logic              hit_2
);
    logic [PTR_W-1:0] age;
    logic             occ;

    assign age   = PTR_W'(IDX) - rd_ptr;
    assign occ   = CNT_W'(age) < count;
    assign hit_1 = occ && (dest == chk_addr_1);
    assign hit_2 = occ && (dest == chk_addr_2);
endmodule

module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_write_queue_if.slave   bus,
    input  logic [ADDR_W-1:0] chk_addr_1,
    input  logic [ADDR_W-1:0] chk_addr_2,
    output logic              chk_busy_1,
    output logic              chk_busy_2,
    output logic              fwd_valid_1,
    output logic              fwd_valid_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [CNT_W-1:0]  count
);
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0][ADDR_W-1:0] dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

    logic              full, empty;
    logic              mem_ready, alu_ready;
    logic              push, pop;
    logic [ADDR_W-1:0] push_dest;
    logic [DATA_W-1:0] push_data;
    logic [DEPTH-1:0]  hit_1, hit_2;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Load unit wins; ready never looks at a same-cycle pop (no pass-through).
    assign mem_ready = !full;
    assign alu_ready = !full && !bus.mem_valid;
    assign push      = (bus.mem_valid && mem_ready) || (bus.alu_valid && alu_ready);
    assign push_dest = bus.mem_valid ? bus.mem_dest : bus.alu_dest;
    assign push_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
    assign pop       = !empty && !bus.wb_hold;

    assign bus.mem_ready      = mem_ready;
    assign bus.alu_ready      = alu_ready;
    assign bus.reg_write_en   = pop;
    assign bus.reg_write_dest = empty ? '0 : dest_q[rd_ptr_q];
    assign bus.reg_write_data = empty ? '0 : data_q[rd_ptr_q];
    assign count              = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dest_d   = dest_q;
        data_d   = data_q;
        if (push) begin
            dest_d[wr_ptr_q] = push_dest;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        wb_wq_slot #(
            .IDX    (i),
            .PTR_W  (PTR_W),
            .CNT_W  (CNT_W),
            .ADDR_W (ADDR_W)
        ) u_slot (
            .rd_ptr     (rd_ptr_q),
            .count      (count_q),
            .dest       (dest_q[i]),
            .chk_addr_1 (chk_addr_1),
            .chk_addr_2 (chk_addr_2),
            .hit_1      (hit_1[i]),
            .hit_2      (hit_2[i])
        );
    end

    assign chk_busy_1 = |hit_1;
    assign chk_busy_2 = |hit_2;

`ifdef WB_QUEUE_BYPASS_EN
    logic [DATA_W-1:0] fwd_sel_1, fwd_sel_2;
    logic [PTR_W-1:0]  fwd_idx;

    // Walk oldest to youngest so the last hit (nearest the write pointer) wins.
    always_comb begin
        fwd_sel_1 = '0;
        fwd_sel_2 = '0;
        fwd_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PTR_W'(k);
            if (hit_1[fwd_idx]) fwd_sel_1 = data_q[fwd_idx];
            if (hit_2[fwd_idx]) fwd_sel_2 = data_q[fwd_idx];
        end
    end

    assign fwd_valid_1 = chk_busy_1;
    assign fwd_valid_2 = chk_busy_2;
    assign fwd_data_1  = fwd_sel_1;
    assign fwd_data_2  = fwd_sel_2;
`else
    assign fwd_valid_1 = 1'b0;
    assign fwd_valid_2 = 1'b0;
    assign fwd_data_1  = '0;
    assign fwd_data_2  = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, single write, priority, full,
// same-register scoreboard/bypass, async reset mid-drain, and pointer wrap.
module tb_wb_write_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] chk_addr_1, chk_addr_2;
    logic              chk_busy_1, chk_busy_2;
    logic              fwd_valid_1, fwd_valid_2;
    logic [DATA_W-1:0] fwd_data_1, fwd_data_2;
    logic [2:0]        count;

    int n_checks = 0;
    int n_err    = 0;

    wb_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .chk_addr_1  (chk_addr_1),
        .chk_addr_2  (chk_addr_2),
        .chk_busy_1  (chk_busy_1),
        .chk_busy_2  (chk_busy_2),
        .fwd_valid_1 (fwd_valid_1),
        .fwd_valid_2 (fwd_valid_2),
        .fwd_data_1  (fwd_data_1),
        .fwd_data_2  (fwd_data_2),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W+DATA_W-1:0] q[$];
        logic [ADDR_W+DATA_W-1:0] head;
        logic exp_en, acc;
        int pushed, cycles;

        bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
        bus.wb_hold   = 1'b0;
        chk_addr_1 = '0; chk_addr_2 = '0;

        // Reset state
        samp();
        chk("rst_count", count, 0);
        chk("rst_wen", bus.reg_write_en, 0);
        chk("rst_wdest", bus.reg_write_dest, 0);
        chk("rst_wdata", bus.reg_write_data, 0);
        chk("rst_busy1", chk_busy_1, 0);
        chk("rst_fwd_valid1", fwd_valid_1, 0);
        chk("rst_fwd_data1", fwd_data_1, 0);
        chk("rst_alu_ready", bus.alu_ready, 1);
        chk("rst_mem_ready", bus.mem_ready, 1);
        bus.mem_valid = 1'b1;
        #1;
        chk("rst_alu_ready_memv", bus.alu_ready, 0);
        chk("rst_mem_ready_memv", bus.mem_ready, 1);
        bus.mem_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Single write
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd3; bus.alu_data = 16'h1234;
        samp();
        chk("t1_alu_ready", bus.alu_ready, 1);
        chk("t1_wen_pre", bus.reg_write_en, 0);
        cyc();
        bus.alu_valid = 1'b0;
        samp();
        chk("t1_wen", bus.reg_write_en, 1);
        chk("t1_wdest", bus.reg_write_dest, 3);
        chk("t1_wdata", bus.reg_write_data, 16'h1234);
        chk("t1_count", count, 1);
        cyc();
        samp();
        chk("t1_wen_after", bus.reg_write_en, 0);
        chk("t1_count_after", count, 0);
        chk("t1_wdest_empty", bus.reg_write_dest, 0);
        cyc();

        // Priority: load before ALU
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd1; bus.alu_data = 16'hAAAA;
        bus.mem_valid = 1'b1; bus.mem_dest = 4'd2; bus.mem_data = 16'h5555;
        samp();
        chk("t2_alu_ready", bus.alu_ready, 0);
        chk("t2_mem_ready", bus.mem_ready, 1);
        cyc();
        bus.mem_valid = 1'b0;
        samp();
        chk("t2_alu_ready_next", bus.alu_ready, 1);
        chk("t2_first_dest", bus.reg_write_dest, 2);
        chk("t2_first_data", bus.reg_write_data, 16'h5555);
        chk("t2_first_en", bus.reg_write_en, 1);
        cyc();
        bus.alu_valid = 1'b0;
        samp();
        chk("t2_second_dest", bus.reg_write_dest, 1);
        chk("t2_second_data", bus.reg_write_data, 16'hAAAA);
        chk("t2_second_count", count, 1);
        cyc();
        samp();
        chk("t2_count_end", count, 0);
        cyc();

        // Full under hold, no pass-through at full
        bus.wb_hold = 1'b1;
        chk_addr_2 = 4'd0;
        for (int i = 0; i < 5; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_dest  = ADDR_W'(i);
            bus.alu_data  = DATA_W'(16'h0010 + i);
            samp();
            chk($sformatf("t3_alu_ready_%0d", i), bus.alu_ready, (i < 4) ? 1 : 0);
            chk($sformatf("t3_count_%0d", i), count, (i < 4) ? i : 4);
            chk($sformatf("t3_wen_%0d", i), bus.reg_write_en, 0);
            cyc();
        end
        bus.alu_valid = 1'b0;
        samp();
        chk("t3_full_count", count, 4);
        chk("t3_full_mem_ready", bus.mem_ready, 0);
        chk("t3_busy_reg0", chk_busy_2, 1);
        cyc();
        bus.wb_hold   = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd9; bus.alu_data = 16'h0099;
        for (int i = 0; i < 4; i++) begin
            samp();
            if (i == 0) chk("t3_no_passthru", bus.alu_ready, 0);
            chk($sformatf("t3_drain_en_%0d", i), bus.reg_write_en, 1);
            chk($sformatf("t3_drain_dest_%0d", i), bus.reg_write_dest, i);
            chk($sformatf("t3_drain_data_%0d", i), bus.reg_write_data, 16'h0010 + i);
            cyc();
            bus.alu_valid = 1'b0;
        end
        samp();
        chk("t3_count_end", count, 0);
        chk("t3_wen_end", bus.reg_write_en, 0);
        cyc();

        // Same register twice, scoreboard and bypass
        bus.wb_hold = 1'b1;
        chk_addr_1 = 4'd5; chk_addr_2 = 4'd6;
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd5; bus.alu_data = 16'h0001;
        samp();
        chk("t4_busy_before", chk_busy_1, 0);
        cyc();
        bus.alu_data = 16'h0002;
        cyc();
        bus.alu_valid = 1'b0;
        samp();
        chk("t4_busy1", chk_busy_1, 1);
        chk("t4_busy2", chk_busy_2, 0);
        chk("t4_count", count, 2);
`ifdef WB_QUEUE_BYPASS_EN
        chk("t4_fwd_valid1", fwd_valid_1, 1);
        chk("t4_fwd_data1", fwd_data_1, 16'h0002);
`else
        chk("t4_fwd_valid1", fwd_valid_1, 0);
        chk("t4_fwd_data1", fwd_data_1, 0);
`endif
        cyc();
        bus.wb_hold = 1'b0;
        samp();
        chk("t4_w1_dest", bus.reg_write_dest, 5);
        chk("t4_w1_data", bus.reg_write_data, 16'h0001);
        chk("t4_w1_busy", chk_busy_1, 1);
        cyc();
        samp();
        chk("t4_w2_data", bus.reg_write_data, 16'h0002);
        chk("t4_w2_busy", chk_busy_1, 1);
`ifdef WB_QUEUE_BYPASS_EN
        chk("t4_w2_fwd", fwd_data_1, 16'h0002);
`endif
        cyc();
        samp();
        chk("t4_busy_drop", chk_busy_1, 0);
        chk("t4_count_end", count, 0);
        cyc();

        // Asynchronous reset mid-drain
        bus.wb_hold = 1'b1;
        chk_addr_1 = 4'd8;
        bus.alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_dest = ADDR_W'(7 + i);
            bus.alu_data = DATA_W'(16'h0700 + i);
            cyc();
        end
        bus.alu_valid = 1'b0;
        samp();
        chk("t5_count3", count, 3);
        chk("t5_busy8", chk_busy_1, 1);
        #1 bus.wb_hold = 1'b0;
        #1 chk("t5_wen_live", bus.reg_write_en, 1);
        chk("t5_head_dest", bus.reg_write_dest, 7);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_count", count, 0);
        chk("t5_rst_wen", bus.reg_write_en, 0);
        chk("t5_rst_wdest", bus.reg_write_dest, 0);
        chk("t5_rst_busy", chk_busy_1, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            samp();
            chk($sformatf("t5_post_wen_%0d", i), bus.reg_write_en, 0);
            chk($sformatf("t5_post_count_%0d", i), count, 0);
        end
        cyc();

        // Back-to-back pushes with random holds across pointer wrap
        pushed = 0;
        cycles = 0;
        while ((pushed < 20 || q.size() != 0) && cycles < 200) begin
            bus.alu_valid = (pushed < 20);
            bus.alu_dest  = ADDR_W'(pushed * 3);
            bus.alu_data  = DATA_W'(16'hC000 + pushed);
            bus.wb_hold   = (pushed < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            samp();
            exp_en = (q.size() != 0) && !bus.wb_hold;
            chk("wrap_en", bus.reg_write_en, exp_en);
            chk("wrap_count", count, q.size());
            chk("wrap_alu_ready", bus.alu_ready, (q.size() < DEPTH) ? 1 : 0);
            if (exp_en) begin
                head = q[0];
                chk("wrap_head", {bus.reg_write_dest, bus.reg_write_data}, head);
            end
            acc = bus.alu_valid && (q.size() < DEPTH);
            if (exp_en) void'(q.pop_front());
            if (acc) begin
                q.push_back({bus.alu_dest, bus.alu_data});
                pushed++;
            end
            cycles++;
            cyc();
        end
        bus.alu_valid = 1'b0;
        samp();
        chk("wrap_all_pushed", pushed, 20);
        chk("wrap_drained", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
